timer_device: RTL and testbench
===============================

// Module: timer_device
// PURPOSE
//  Memory-mapped millisecond timer on the I/O bus, one of the devices inside the I/O controller.
//  Prescales the system clock to a 1 ms tick, counts ticks in TCNT, and wraps at limit TLIM.
//  Each wrap sets a sticky Ready flag, and sets Overrun if Ready was already set.
//  Raises IRQ, which the controller ORs and prioritises as device ID 1.
// PARAMETERS
//  TICK_DIV   50000        clk cycles per tick (1 ms at 50 MHz); must be >= 2
//  ADDR_TCNT  32'hF0000020 counter register address
//  ADDR_TLIM  32'hF0000024 limit register address
//  ADDR_TCTL  32'hF0000120 control/status register address
// PORTS
//  clk   in     1   system clock; all state changes on posedge
//  rst   in     1   synchronous reset, active-high
//  ABUS  in     32  bus address (word-aligned byte address)
//  DBUS  inout  32  shared data bus (tri); driven only on read hit, else 32'bz
//  we    in     1   bus write strobe; the write commits on the posedge where we=1
//  IE    in     1   global interrupt enable from the system register file
//  IRQ   out    1   interrupt request, level-sensitive
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - prescaler=0, TCNT=0, TLIM=0, TCTL=0, so IRQ=0.
//   - Reset has priority over bus writes and ticks, including mid-count.
//  Prescaler:
//   - Counts 0..TICK_DIV-1, then wraps to 0.
//   - tick is a 1-cycle internal pulse in the cycle the prescaler = TICK_DIV-1.
//  TCNT (32b), on tick:
//   - If TLIM != 0 and TCNT+1 >= TLIM: TCNT<=0 and wrap=1.
//   - Otherwise: TCNT<=TCNT+1, wrapping from 2^32-1 to 0 with no flag.
//   - TLIM=0 means the limit is disabled: free-running, never wraps, never sets Ready.
//  TCTL bit fields:
//   - bit0 Ready: set on wrap.
//   - bit2 Overrun: set on a wrap while Ready is already 1.
//   - bit8 IE: timer-local interrupt enable.
//   - All other bits read 0.
//  TCTL writes:
//   - bit0 and bit2 are clear-only: writing 0 clears, writing 1 leaves the bit unchanged.
//   - bit8 is written directly.
//  Simultaneous wrap and TCTL write in the same cycle:
//   - Set beats clear: Ready ends at 1.
//   - Overrun is evaluated against Ready before the write.
//  TCNT write:
//   - Loads DBUS and overrides the same-cycle tick increment.
//   - The tick is lost and no wrap occurs in that cycle.
//  TLIM write:
//   - Loads DBUS; TCNT is unchanged.
//   - A new TLIM <= TCNT wraps on the next tick.
//  Reads:
//   - When we=0 and ABUS hits a register, DBUS = that register value combinationally.
//   - On a miss or when we=1, DBUS = 32'bz.
//   - Reads have no side effects.
//  IRQ = TCTL.Ready & TCTL.IE & IE (combinational).
//   - IRQ rises 1 cycle after the wrapping tick edge.
//   - IRQ stays high until software clears Ready or either enable drops.
//  Writes to any non-matching address are ignored.
// TESTING (bench uses TICK_DIV=4)
//  1. Reset, then idle 40 clks:
//     -> TCNT=10, TCTL=0, IRQ=0.
//  2. Write TLIM=3, TCTL=0x100, IE=1; run 12 ticks:
//     -> TCNT cycles 0,1,2,0.
//     -> Ready=1 after the first wrap; IRQ=1 from then on.
//     -> Overrun=1 after the second wrap.
//  3. With Ready=1 and Overrun=1, write TCTL=0x105:
//     -> unchanged.
//     Then write TCTL=0x100:
//     -> TCTL=0x100, IRQ=0.
//  4. Write TCTL=0x100 in the exact cycle of a wrapping tick:
//     -> Ready=1, Overrun unchanged, IRQ=1.
//  5. Write TCNT=7 on a tick cycle with TLIM=0:
//     -> TCNT=7, not 8.
//     Then set TLIM=5:
//     -> the next tick wraps TCNT to 0 and sets Ready.
//  6. Assert rst mid-count with TCNT=2 and Ready=1:
//     -> all registers 0 and IRQ=0 next cycle.
//     -> Also check DBUS=z whenever we=1 or the address misses.

Source files
------------

// File: rtl/timer_device.sv
// -----------------------------------------------------------------------------
// timer_device
//   Memory-mapped millisecond timer living on the I/O bus. A prescaler divides
//   the system clock down to a tick. TCNT counts ticks and wraps at TLIM.
//   Each wrap sets the sticky Ready flag, and sets Overrun if Ready was
//   already pending. The level-sensitive IRQ is picked up by the I/O
//   controller as device ID 1.
//
// Ports
//   clk   in     1   system clock, all state changes on posedge
//   rst   in     1   synchronous reset, active-high, highest priority
//   ABUS  in     32  word-aligned byte address
//   DBUS  inout  32  shared data bus; driven only on a read hit, else 'z
//   we    in     1   write strobe; a write commits on the posedge where we=1
//   IE    in     1   global interrupt enable from the system register file
//   IRQ   out    1   interrupt request = Ready & local IE & global IE
//
// Register map
//   ADDR_TCNT  tick counter (R/W)
//   ADDR_TLIM  wrap limit, 0 disables wrapping (R/W)
//   ADDR_TCTL  bit0 Ready (W0C), bit2 Overrun (W0C), bit8 local IE (R/W)
// -----------------------------------------------------------------------------
module timer_device #(
    parameter int unsigned TICK_DIV  = 50000,
    parameter logic [31:0] ADDR_TCNT = 32'hF000_0020,
    parameter logic [31:0] ADDR_TLIM = 32'hF000_0024,
    parameter logic [31:0] ADDR_TCTL = 32'hF000_0120
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ABUS,
    inout  tri   logic [31:0] DBUS,
    input  logic        we,
    input  logic        IE,
    output logic        IRQ
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    // State flops
    logic [PW-1:0] presc_q, presc_d;
    logic [31:0]   tcnt_q,  tcnt_d;
    logic [31:0]   tlim_q,  tlim_d;
    logic          ready_q, ready_d;
    logic          ovr_q,   ovr_d;
    logic          tie_q,   tie_d;

    // Combinational helpers
    logic          tick_s;
    logic          wrap_s;
    logic [32:0]   tcnt_inc_s;
    logic          wr_tcnt_s;
    logic          wr_tlim_s;
    logic          wr_tctl_s;
    logic [31:0]   wdata_s;
    logic [31:0]   tctl_s;
    logic          rd_hit_s;
    logic [31:0]   rd_data_s;

    // Write data is whatever the bus master is driving onto the shared bus
    assign wdata_s = DBUS;

    // Status/control register as seen by software; unused bits read as zero
    assign tctl_s = {23'd0, tie_q, 5'd0, ovr_q, 1'b0, ready_q};

    // Address decode for writes and the tick/wrap qualifiers
    always_comb begin
        wr_tcnt_s = we && (ABUS == ADDR_TCNT);
        wr_tlim_s = we && (ABUS == ADDR_TLIM);
        wr_tctl_s = we && (ABUS == ADDR_TCTL);
        tick_s    = (presc_q == PRESC_MAX);
        // 33-bit increment so a counter sitting at 2^32-1 still honours the limit
        tcnt_inc_s = {1'b0, tcnt_q} + 33'd1;
        // A TCNT write swallows the tick, so it can never wrap in that cycle
        if (tick_s && !wr_tcnt_s && (tlim_q != 32'd0)) begin
            wrap_s = (tcnt_inc_s >= {1'b0, tlim_q});
        end else begin
            wrap_s = 1'b0;
        end
    end

    // Next-state logic for the prescaler
    always_comb begin
        presc_d = presc_q;
        if (tick_s) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    // Next-state logic for TCNT and TLIM
    always_comb begin
        tcnt_d = tcnt_q;
        tlim_d = tlim_q;
        if (wr_tcnt_s) begin
            tcnt_d = wdata_s;
        end else if (wrap_s) begin
            tcnt_d = 32'd0;
        end else if (tick_s) begin
            tcnt_d = tcnt_inc_s[31:0];
        end else begin
            tcnt_d = tcnt_q;
        end
        if (wr_tlim_s) begin
            tlim_d = wdata_s;
        end else begin
            tlim_d = tlim_q;
        end
    end

    // Next-state logic for TCTL: clear-only status bits, set beats clear
    always_comb begin
        ready_d = ready_q;
        ovr_d   = ovr_q;
        tie_d   = tie_q;
        // Software clears by writing 0; a 1 leaves the flag alone
        if (wr_tctl_s) begin
            ready_d = ready_q & wdata_s[0];
            tie_d   = wdata_s[8];
        end else begin
            ready_d = ready_q;
            tie_d   = tie_q;
        end
        if (wrap_s) begin
            ready_d = 1'b1;
        end else begin
            ready_d = ready_d;
        end
        // Overrun looks at Ready as it stood before any same-cycle write
        if (wrap_s && ready_q) begin
            ovr_d = 1'b1;
        end else if (wr_tctl_s) begin
            ovr_d = ovr_q & wdata_s[2];
        end else begin
            ovr_d = ovr_q;
        end
    end

    // Register state; reset wins over writes and ticks
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            tcnt_q  <= 32'd0;
            tlim_q  <= 32'd0;
            ready_q <= 1'b0;
            ovr_q   <= 1'b0;
            tie_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tcnt_q  <= tcnt_d;
            tlim_q  <= tlim_d;
            ready_q <= ready_d;
            ovr_q   <= ovr_d;
            tie_q   <= tie_d;
        end
    end

    // Read mux; only a hit with we=0 lets the device drive the bus
    always_comb begin
        rd_hit_s  = 1'b0;
        rd_data_s = 32'd0;
        if (we) begin
            rd_hit_s  = 1'b0;
            rd_data_s = 32'd0;
        end else if (ABUS == ADDR_TCNT) begin
            rd_hit_s  = 1'b1;
            rd_data_s = tcnt_q;
        end else if (ABUS == ADDR_TLIM) begin
            rd_hit_s  = 1'b1;
            rd_data_s = tlim_q;
        end else if (ABUS == ADDR_TCTL) begin
            rd_hit_s  = 1'b1;
            rd_data_s = tctl_s;
        end else begin
            rd_hit_s  = 1'b0;
            rd_data_s = 32'd0;
        end
    end

    assign DBUS = rd_hit_s ? rd_data_s : 32'bz;

    // Level interrupt straight from the registered Ready flag and both enables
    assign IRQ = ready_q & tie_q & IE;

endmodule

// File: tb/tb_timer_device.sv
// -----------------------------------------------------------------------------
// tb_timer_device
//   Scenario-driven bench for timer_device with TICK_DIV=4. Each scenario task
//   pushes its expected values into a scoreboard queue as it drives stimulus,
//   then pops and compares when the DUT output is observed.
//   Tick timing is tracked by counting non-reset clock edges since reset, so a
//   write can be placed exactly on a tick edge.
// -----------------------------------------------------------------------------
module tb_timer_device;

    localparam logic [31:0] A_TCNT = 32'hF000_0020;
    localparam logic [31:0] A_TLIM = 32'hF000_0024;
    localparam logic [31:0] A_TCTL = 32'hF000_0120;
    localparam logic [31:0] A_MISS = 32'hF000_0028;
    localparam logic [31:0] A_ALIAS = 32'hF000_0124;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] abus;
    logic        we;
    logic        ie;
    wire         irq;
    wire  [31:0] dbus;
    logic        drv_en;
    logic [31:0] drv_val;

    int cmp_cnt = 0;
    int err_cnt = 0;
    int unsigned cyc = 0;
    logic [31:0] exp_q[$];

    assign dbus = drv_en ? drv_val : 32'bz;

    timer_device #(.TICK_DIV(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .ABUS (abus),
        .DBUS (dbus),
        .we   (we),
        .IE   (ie),
        .IRQ  (irq)
    );

    always #5 clk = ~clk;

    // Prescaler position as the bench expects it: edges since reset
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        abus = a; we = 1'b0; #1; v = dbus;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, output logic [31:0] obs);
        @(negedge clk);
        abus = a; we = 1'b1; drv_val = d; drv_en = 1'b1;
        #1; obs = dbus;
        @(posedge clk); #1;
        we = 1'b0; drv_en = 1'b0; abus = 32'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Advance until the next posedge is a tick edge
    task automatic align_tick();
        int guard = 0;
        while ((cyc % 4) != 3 && guard < 8) begin
            @(posedge clk); #1; guard++;
        end
        if (guard >= 8) begin
            cmp_cnt++; err_cnt++;
            $display("FAIL align_tick: prescaler phase %0d never reached 3", cyc % 4);
        end
    endtask

    task automatic tick_once();
        align_tick();
        idle(1);
    endtask

    task automatic test_reset();
        logic [31:0] obs, e, wobs;
        logic [31:0] addrs[3];
        addrs = '{A_TCNT, A_TCTL, A_TLIM};
        rst = 1'b1; we = 1'b0; ie = 1'b0; drv_en = 1'b0; drv_val = 32'h0; abus = 32'h0;
        @(posedge clk); @(posedge clk); #1; rst = 1'b0;
        exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        foreach (addrs[i]) begin
            rd(addrs[i], obs); e = exp_q.pop_front(); cmp_cnt++;
            if (obs !== e) begin err_cnt++; $display("FAIL reset_reg %h: got %h expected %h", addrs[i], obs, e); end
        end
        cmp_cnt++;
        if (irq !== 1'b0) begin err_cnt++; $display("FAIL reset_irq: got %b expected 0", irq); end
        // 40 idle clocks at 4 clocks per tick
        idle(40);
        exp_q.push_back(32'd10); exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        foreach (addrs[i]) begin
            rd(addrs[i], obs); e = exp_q.pop_front(); cmp_cnt++;
            if (obs !== e) begin err_cnt++; $display("FAIL idle40_reg %h: got %h expected %h", addrs[i], obs, e); end
        end
        e = exp_q.pop_front(); cmp_cnt++;
        if ({31'd0, irq} !== e) begin err_cnt++; $display("FAIL idle40_irq: got %b expected %0d", irq, e); end
        // Near-miss address must be ignored, and a miss read must leave the bus alone
        bus_write(A_ALIAS, 32'd7, wobs);
        exp_q.push_back(32'd0); exp_q.push_back(32'd10); exp_q.push_back(32'h5A5A_C3C3);
        rd(A_TLIM, obs); e = exp_q.pop_front(); cmp_cnt++;
        if (obs !== e) begin err_cnt++; $display("FAIL alias_tlim: got %h expected %h", obs, e); end
        rd(A_TCNT, obs); e = exp_q.pop_front(); cmp_cnt++;
        if (obs !== e) begin err_cnt++; $display("FAIL alias_tcnt: got %h expected %h", obs, e); end
        drv_val = 32'h5A5A_C3C3; drv_en = 1'b1;
        rd(A_MISS, obs); e = exp_q.pop_front(); cmp_cnt++;
        drv_en = 1'b0;
        if (obs !== e) begin err_cnt++; $display("FAIL miss_read_bus: got %h expected %h", obs, e); end
    endtask

    task automatic test_wrap_sequence();
        logic [31:0] obs, e, wobs;
        align_tick();
        bus_write(A_TCNT, 32'd0, wobs);   // lands on a tick: counter must read 0, not 11
        bus_write(A_TLIM, 32'd3, wobs);
        bus_write(A_TCTL, 32'h100, wobs);
        ie = 1'b1;
        exp_q.push_back(32'd0);
        rd(A_TCNT, obs); e = exp_q.pop_front(); cmp_cnt++;
        if (obs !== e) begin err_cnt++; $display("FAIL setup_tcnt: got %h expected %h", obs, e); end
        for (int k = 1; k <= 12; k++) begin
            exp_q.push_back(32'(k % 3));
            exp_q.push_back((k < 3) ? 32'h100 : ((k < 6) ? 32'h101 : 32'h105));
            exp_q.push_back((k >= 3) ? 32'd1 : 32'd0);
            tick_once();
            rd(A_TCNT, obs); e = exp_q.pop_front(); cmp_cnt++;
            if (obs !== e) begin err_cnt++; $display("FAIL wrap_tcnt tick%0d: got %h expected %h", k, obs, e); end
            rd(A_TCTL, obs); e = exp_q.pop_front(); cmp_cnt++;
            if (obs !== e) begin err_cnt++; $display("FAIL wrap_tctl tick%0d: got %h expected %h", k, obs, e); end
            e = exp_q.pop_front(); cmp_cnt++;
            if ({31'd0, irq} !== e) begin err_cnt++; $display("FAIL wrap_irq tick%0d: got %b expected %0d", k, irq, e); end
        end
    endtask

    task automatic test_tctl_clear();
        logic [31:0] obs, e, wobs;
        bus_write(A_TCTL, 32'h105, wobs);
        exp_q.push_back(32'h105); exp_q.push_back(32'd1);
        rd(A_TCTL, obs); e = exp_q.pop_front(); cmp_cnt++;
        if (obs !== e) begin err_cnt++; $display("FAIL w1_keeps_tctl: got %h expected %h", obs, e); end
        e = exp_q.pop_front(); cmp_cnt++;
        if ({31'd0, irq} !== e) begin err_cnt++; $display("FAIL w1_keeps_irq: got %b expected %0d", irq, e); end
        exp_q.push_back(32'h100);
        bus_write(A_TCTL, 32'h100, wobs);
        e = exp_q.pop_front(); cmp_cnt++;
        if (wobs !== e) begin err_cnt++; $display("FAIL write_bus_float: got %h expected %h", wobs, e); end
        exp_q.push_back(32'h100); exp_q.push_back(32'd0);
        rd(A_TCTL, obs); e = exp_q.pop_front(); cmp_cnt++;
        if (obs !== e) begin err_cnt++; $display("FAIL w0_clears_tctl: got %h expected %h", obs, e); end
        e = exp_q.pop_front(); cmp_cnt++;
        if ({31'd0, irq} !== e) begin err_cnt++; $display("FAIL w0_clears_irq: got %b expected %0d", irq, e); end
    endtask

    task automatic test_wrap_write_collision();
        logic [31:0] obs, e, wobs;
        // Counter at 0 with TLIM=3: two ticks to 2, the third one wraps
        tick_once(); tick_once();
        align_tick();
        bus_write(A_TCTL, 32'h100, wobs);
        exp_q.push_back(32'h101); exp_q.push_back(32'd0); exp_q.push_back(32'd1);
        rd(A_TCTL, obs); e = exp_q.pop_front(); cmp_cnt++;
        if (obs !== e) begin err_cnt++; $display("FAIL collide1_tctl: got %h expected %h", obs, e); end
        rd(A_TCNT, obs); e = exp_q.pop_front(); cmp_cnt++;
        if (obs !== e) begin err_cnt++; $display("FAIL collide1_tcnt: got %h expected %h", obs, e); end
        e = exp_q.pop_front(); cmp_cnt++;
        if ({31'd0, irq} !== e) begin err_cnt++; $display("FAIL collide1_irq: got %b expected %0d", irq, e); end
        // Same again with Ready already set: the wrap also raises Overrun
        tick_once(); tick_once();
        align_tick();
        bus_write(A_TCTL, 32'h100, wobs);
        exp_q.push_back(32'h105);
        rd(A_TCTL, obs); e = exp_q.pop_front(); cmp_cnt++;
        if (obs !== e) begin err_cnt++; $display("FAIL collide2_tctl: got %h expected %h", obs, e); end
    endtask

    task automatic test_tcnt_write();
        logic [31:0] obs, e, wobs;
        bus_write(A_TLIM, 32'd0, wobs);
        bus_write(A_TCTL, 32'h100, wobs);
        align_tick();
        bus_write(A_TCNT, 32'd7, wobs);
        exp_q.push_back(32'd7);
        rd(A_TCNT, obs); e = exp_q.pop_front(); cmp_cnt++;
        if (obs !== e) begin err_cnt++; $display("FAIL tcnt_write_on_tick: got %h expected %h", obs, e); end
        bus_write(A_TLIM, 32'd5, wobs);
        exp_q.push_back(32'd7); exp_q.push_back(32'd5); exp_q.push_back(32'h100);
        rd(A_TCNT, obs); e = exp_q.pop_front(); cmp_cnt++;
        if (obs !== e) begin err_cnt++; $display("FAIL tlim_write_tcnt: got %h expected %h", obs, e); end
        rd(A_TLIM, obs); e = exp_q.pop_front(); cmp_cnt++;
        if (obs !== e) begin err_cnt++; $display("FAIL tlim_readback: got %h expected %h", obs, e); end
        rd(A_TCTL, obs); e = exp_q.pop_front(); cmp_cnt++;
        if (obs !== e) begin err_cnt++; $display("FAIL tlim_write_tctl: got %h expected %h", obs, e); end
        tick_once();
        exp_q.push_back(32'd0); exp_q.push_back(32'h101); exp_q.push_back(32'd1);
        rd(A_TCNT, obs); e = exp_q.pop_front(); cmp_cnt++;
        if (obs !== e) begin err_cnt++; $display("FAIL low_limit_tcnt: got %h expected %h", obs, e); end
        rd(A_TCTL, obs); e = exp_q.pop_front(); cmp_cnt++;
        if (obs !== e) begin err_cnt++; $display("FAIL low_limit_tctl: got %h expected %h", obs, e); end
        e = exp_q.pop_front(); cmp_cnt++;
        if ({31'd0, irq} !== e) begin err_cnt++; $display("FAIL low_limit_irq: got %b expected %0d", irq, e); end
    endtask

    task automatic test_reset_midcount();
        logic [31:0] obs, e;
        logic [31:0] addrs[3];
        addrs = '{A_TCNT, A_TLIM, A_TCTL};
        tick_once(); tick_once();
        exp_q.push_back(32'd2); exp_q.push_back(32'd1);
        rd(A_TCNT, obs); e = exp_q.pop_front(); cmp_cnt++;
        if (obs !== e) begin err_cnt++; $display("FAIL pre_rst_tcnt: got %h expected %h", obs, e); end
        e = exp_q.pop_front(); cmp_cnt++;
        if ({31'd0, irq} !== e) begin err_cnt++; $display("FAIL pre_rst_irq: got %b expected %0d", irq, e); end
        // Reset lands together with a tick and a TCNT write
        align_tick();
        @(negedge clk);
        rst = 1'b1; abus = A_TCNT; we = 1'b1; drv_val = 32'd9; drv_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; we = 1'b0; drv_en = 1'b0; abus = 32'h0;
        exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        foreach (addrs[i]) begin
            rd(addrs[i], obs); e = exp_q.pop_front(); cmp_cnt++;
            if (obs !== e) begin err_cnt++; $display("FAIL midrst_reg %h: got %h expected %h", addrs[i], obs, e); end
        end
        e = exp_q.pop_front(); cmp_cnt++;
        if ({31'd0, irq} !== e) begin err_cnt++; $display("FAIL midrst_irq: got %b expected %0d", irq, e); end
        // Prescaler restarted too: first tick four edges after reset
        exp_q.push_back(32'd0); exp_q.push_back(32'd1);
        idle(3);
        rd(A_TCNT, obs); e = exp_q.pop_front(); cmp_cnt++;
        if (obs !== e) begin err_cnt++; $display("FAIL post_rst_3clk: got %h expected %h", obs, e); end
        idle(1);
        rd(A_TCNT, obs); e = exp_q.pop_front(); cmp_cnt++;
        if (obs !== e) begin err_cnt++; $display("FAIL post_rst_4clk: got %h expected %h", obs, e); end
    endtask

    initial begin
        test_reset();
        test_wrap_sequence();
        test_tctl_clear();
        test_wrap_write_collision();
        test_tcnt_write();
        test_reset_midcount();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
